// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur game: FSM states, screen geometry,
// datapath widths and the BCD magnitude compare used for the best-score update.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned SPEED_W  = 4;
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned DIGITS   = 4;

    // Strictly-greater compare of two packed BCD values, most significant digit first.
    function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed BCD up-counter with synchronous clear; holds at 9999.
module bcd_counter4
    import dino_pkg::*;
(
    input  logic               clkdiv,
    input  logic               RESET,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] value
);

    logic [SCORE_W-1:0] value_q;
    logic [SCORE_W-1:0] value_d;
    logic               carry;

    // Ripple the increment through the digits; clear takes priority.
    always_comb begin
        value_d = value_q;
        carry   = inc && (value_q != 16'h9999);
        if (clear) begin
            value_d = '0;
        end else begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (carry) begin
                    if (value_q[i*4 +: 4] == 4'd9) begin
                        value_d[i*4 +: 4] = 4'd0;
                    end else begin
                        value_d[i*4 +: 4] = value_q[i*4 +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: collision detection on the sprite pixel streams, the
// IDLE/RUN/OVER machine, score/best-score keeping and scroll-speed ramp.
module game_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned SCORE_DIV  = 6,
    parameter int unsigned SPEED_STEP = 600,
    parameter int unsigned SPEED_INIT = 3,
    parameter int unsigned SPEED_MAX  = 15
) (
    input  logic               clkdiv,
    input  logic               RESET,
    input  logic               start,
    input  logic               fresh,
    input  logic [8:0]         row_addr,
    input  logic [9:0]         col_addr,
    input  logic               cactus_px,
    input  logic               dino_px,
    output logic               game_status,
    output logic               restart,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score
);

    localparam int unsigned DIV_W  = $clog2(SCORE_DIV);
    localparam int unsigned STEP_W = 10;

    state_e              state_q, state_d;
    logic [1:0]          start_sync_q;
    logic                start_prev_q;
    logic                fresh_q;
    logic                hit_q, hit_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [SCORE_W-1:0]  hi_score_q, hi_score_d;
    logic                game_status_q, restart_q;
    logic                start_rise, frame_tick, coincide, collide;
    logic                enter_run, score_inc;

    assign start_rise = start_sync_q[1] & ~start_prev_q;
    assign frame_tick = fresh_q & ~fresh;
    assign coincide   = cactus_px & dino_px
                      & (row_addr < 9'(V_ACTIVE)) & (col_addr < 10'(H_ACTIVE));
    assign collide    = hit_q | coincide;

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        div_cnt_d  = div_cnt_q;
        step_cnt_d = step_cnt_q;
        speed_d    = speed_q;
        hi_score_d = hi_score_q;
        enter_run  = 1'b0;
        score_inc  = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (frame_tick) begin
                    if (collide) begin
                        state_d = OVER;
                        if (bcd_gt(score, hi_score_q)) begin
                            hi_score_d = score;
                        end
                    end else begin
                        if (div_cnt_q == DIV_W'(SCORE_DIV - 1)) begin
                            div_cnt_d = '0;
                            score_inc = 1'b1;
                        end else begin
                            div_cnt_d = div_cnt_q + DIV_W'(1);
                        end
                        if (step_cnt_q == STEP_W'(SPEED_STEP - 1)) begin
                            step_cnt_d = '0;
                            if (speed_q < SPEED_W'(SPEED_MAX)) begin
                                speed_d = speed_q + SPEED_W'(1);
                            end
                        end else begin
                            step_cnt_d = step_cnt_q + STEP_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Collision latch spans one frame; the tick cycle itself is covered by collide.
        if (enter_run || frame_tick) begin
            hit_d = 1'b0;
        end else if ((state_q == RUN) && coincide) begin
            hit_d = 1'b1;
        end

        if (enter_run) begin
            div_cnt_d  = '0;
            step_cnt_d = '0;
            speed_d    = SPEED_W'(SPEED_INIT);
        end
    end

    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            start_sync_q  <= '0;
            start_prev_q  <= 1'b0;
            fresh_q       <= 1'b0;
            hit_q         <= 1'b0;
            div_cnt_q     <= '0;
            step_cnt_q    <= '0;
            speed_q       <= SPEED_W'(SPEED_INIT);
            hi_score_q    <= '0;
            game_status_q <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_sync_q  <= {start_sync_q[0], start};
            start_prev_q  <= start_sync_q[1];
            fresh_q       <= fresh;
            hit_q         <= hit_d;
            div_cnt_q     <= div_cnt_d;
            step_cnt_q    <= step_cnt_d;
            speed_q       <= speed_d;
            hi_score_q    <= hi_score_d;
            game_status_q <= (state_d == RUN);
            restart_q     <= enter_run;
        end
    end

    bcd_counter4 u_score (
        .clkdiv (clkdiv),
        .RESET  (RESET),
        .clear  (enter_run),
        .inc    (score_inc),
        .value  (score)
    );

    assign game_status = game_status_q;
    assign restart     = restart_q;
    assign speed       = speed_q;
    assign hi_score    = hi_score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a default-parameter instance plus a fast-ramp
// instance (SCORE_DIV=2, SPEED_STEP=4) sharing the same stimulus.
module tb_game_ctrl;

    logic        clkdiv = 1'b0;
    logic        RESET  = 1'b1;
    logic        start  = 1'b0;
    logic        fresh  = 1'b0;
    logic [8:0]  row_addr = '0;
    logic [9:0]  col_addr = '0;
    logic        cactus_px = 1'b0;
    logic        dino_px   = 1'b0;

    logic        gs_a, rs_a, gs_b, rs_b;
    logic [3:0]  sp_a, sp_b;
    logic [15:0] sc_a, hi_a, sc_b, hi_b;

    localparam int S_GS_A = 0, S_RS_A = 1, S_SP_A = 2, S_SC_A = 3, S_HI_A = 4;
    localparam int S_GS_B = 5, S_RS_B = 6, S_SP_B = 7, S_SC_B = 8, S_HI_B = 9;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clkdiv = ~clkdiv;

    game_ctrl u_dut (
        .clkdiv (clkdiv), .RESET (RESET), .start (start), .fresh (fresh),
        .row_addr (row_addr), .col_addr (col_addr),
        .cactus_px (cactus_px), .dino_px (dino_px),
        .game_status (gs_a), .restart (rs_a), .speed (sp_a),
        .score (sc_a), .hi_score (hi_a)
    );

    game_ctrl #(.SCORE_DIV(2), .SPEED_STEP(4), .SPEED_INIT(3), .SPEED_MAX(15)) u_fast (
        .clkdiv (clkdiv), .RESET (RESET), .start (start), .fresh (fresh),
        .row_addr (row_addr), .col_addr (col_addr),
        .cactus_px (cactus_px), .dino_px (dino_px),
        .game_status (gs_b), .restart (rs_b), .speed (sp_b),
        .score (sc_b), .hi_score (hi_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_GS_A: return 32'(gs_a);
            S_RS_A: return 32'(rs_a);
            S_SP_A: return 32'(sp_a);
            S_SC_A: return 32'(sc_a);
            S_HI_A: return 32'(hi_a);
            S_GS_B: return 32'(gs_b);
            S_RS_B: return 32'(rs_b);
            S_SP_B: return 32'(sp_b);
            S_SC_B: return 32'(sc_b);
            S_HI_B: return 32'(hi_b);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic sb_push(input int sel, input string tag, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic exp_a(input string p, input logic gs, input logic [3:0] sp,
                         input logic [15:0] sc, input logic [15:0] hi);
        sb_push(S_GS_A, {p, ".a.gs"}, 32'(gs));
        sb_push(S_SP_A, {p, ".a.speed"}, 32'(sp));
        sb_push(S_SC_A, {p, ".a.score"}, 32'(sc));
        sb_push(S_HI_A, {p, ".a.hi"}, 32'(hi));
    endtask

    task automatic exp_b(input string p, input logic gs, input logic [3:0] sp,
                         input logic [15:0] sc, input logic [15:0] hi);
        sb_push(S_GS_B, {p, ".b.gs"}, 32'(gs));
        sb_push(S_SP_B, {p, ".b.speed"}, 32'(sp));
        sb_push(S_SC_B, {p, ".b.score"}, 32'(sc));
        sb_push(S_HI_B, {p, ".b.hi"}, 32'(hi));
    endtask

    task automatic step();
        @(posedge clkdiv);
        #1;
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            fresh = 1'b1;
            step();
            fresh = 1'b0;
            step();
        end
    endtask

    task automatic pulse_px(input logic [8:0] r, input logic [9:0] c);
        row_addr  = r;
        col_addr  = c;
        cactus_px = 1'b1;
        dino_px   = 1'b1;
        step();
        cactus_px = 1'b0;
        dino_px   = 1'b0;
        row_addr  = '0;
        col_addr  = '0;
    endtask

    // Frame whose tick cycle carries an on-screen coincidence.
    task automatic frame_hit_on_tick();
        fresh = 1'b1;
        step();
        fresh = 1'b0;
        row_addr  = 9'd200;
        col_addr  = 10'd50;
        cactus_px = 1'b1;
        dino_px   = 1'b1;
        step();
        cactus_px = 1'b0;
        dino_px   = 1'b0;
    endtask

    // Ten-cycle start press from IDLE/OVER with the 3-cycle latency checks.
    task automatic start_game(input string p);
        start = 1'b1;
        step();
        step();
        sb_push(S_GS_A, {p, ".gs_at_2"}, 32'd0);
        sb_drain();
        step();
        sb_push(S_GS_A, {p, ".gs_at_3"}, 32'd1);
        sb_push(S_RS_A, {p, ".restart_at_3"}, 32'd1);
        sb_push(S_SP_A, {p, ".speed_at_3"}, 32'd3);
        sb_push(S_SC_A, {p, ".score_at_3"}, 32'd0);
        sb_push(S_GS_B, {p, ".b.gs_at_3"}, 32'd1);
        sb_push(S_SP_B, {p, ".b.speed_at_3"}, 32'd3);
        sb_drain();
        step();
        sb_push(S_RS_A, {p, ".restart_at_4"}, 32'd0);
        sb_push(S_RS_B, {p, ".b.restart_at_4"}, 32'd0);
        sb_drain();
        repeat (6) step();
        start = 1'b0;
        step();
    endtask

    initial begin
        repeat (3) step();
        exp_a("reset", 1'b0, 4'd3, 16'h0000, 16'h0000);
        exp_b("reset", 1'b0, 4'd3, 16'h0000, 16'h0000);
        sb_push(S_RS_A, "reset.a.restart", 32'd0);
        sb_drain();
        RESET = 1'b0;
        repeat (2) step();

        start_game("start1");

        run_frames(12);
        exp_a("clean12", 1'b1, 4'd3, 16'h0002, 16'h0000);
        exp_b("clean12", 1'b1, 4'd6, 16'h0006, 16'h0000);
        sb_drain();

        pulse_px(9'd350, 10'd100);
        sb_push(S_GS_A, "hit_pre_tick.gs", 32'd1);
        sb_drain();
        run_frames(1);
        exp_a("over1", 1'b0, 4'd3, 16'h0002, 16'h0002);
        exp_b("over1", 1'b0, 4'd6, 16'h0006, 16'h0006);
        sb_drain();

        // Start edge lands in the same cycle as a frame tick while in OVER.
        start = 1'b1;
        step();
        fresh = 1'b1;
        step();
        fresh = 1'b0;
        step();
        sb_push(S_RS_A, "start_on_tick.restart", 32'd1);
        exp_a("start_on_tick", 1'b1, 4'd3, 16'h0000, 16'h0002);
        exp_b("start_on_tick", 1'b1, 4'd3, 16'h0000, 16'h0006);
        sb_drain();
        repeat (4) step();
        start = 1'b0;
        step();

        pulse_px(9'd350, 10'd700);
        run_frames(1);
        pulse_px(9'd480, 10'd100);
        run_frames(1);
        sb_push(S_GS_A, "offscreen.gs", 32'd1);
        sb_drain();
        run_frames(4);
        exp_a("run6", 1'b1, 4'd3, 16'h0001, 16'h0002);
        exp_b("run6", 1'b1, 4'd4, 16'h0003, 16'h0006);
        sb_drain();

        run_frames(5);
        frame_hit_on_tick();
        exp_a("tick_hit", 1'b0, 4'd3, 16'h0001, 16'h0002);
        exp_b("tick_hit", 1'b0, 4'd5, 16'h0005, 16'h0006);
        sb_drain();

        start_game("start2");
        run_frames(7199);
        sb_push(S_SP_A, "f7199.a.speed", 32'd14);
        sb_drain();
        run_frames(1);
        sb_push(S_SP_A, "f7200.a.speed", 32'd15);
        sb_drain();
        run_frames(12798);
        exp_a("f19998", 1'b1, 4'd15, 16'h3333, 16'h0002);
        exp_b("f19998", 1'b1, 4'd15, 16'h9999, 16'h0006);
        sb_drain();
        run_frames(12);
        exp_a("f20010", 1'b1, 4'd15, 16'h3335, 16'h0002);
        exp_b("f20010", 1'b1, 4'd15, 16'h9999, 16'h0006);
        sb_drain();

        pulse_px(9'd10, 10'd639);
        run_frames(1);
        exp_a("over_big", 1'b0, 4'd15, 16'h3335, 16'h3335);
        exp_b("over_big", 1'b0, 4'd15, 16'h9999, 16'h9999);
        sb_drain();

        start_game("start3");
        run_frames(606);
        exp_a("pre_reset", 1'b1, 4'd4, 16'h0101, 16'h3335);
        sb_drain();

        // Asynchronous reset mid-cycle, sampled before the next clock edge.
        step();
        #2;
        RESET = 1'b1;
        #1;
        exp_a("async_reset", 1'b0, 4'd3, 16'h0000, 16'h0000);
        exp_b("async_reset", 1'b0, 4'd3, 16'h0000, 16'h0000);
        sb_push(S_RS_A, "async_reset.a.restart", 32'd0);
        sb_drain();
        step();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            sb_push(S_RS_A, "post_reset.restart", 32'd0);
            sb_push(S_GS_A, "post_reset.gs", 32'd0);
            sb_drain();
        end
        run_frames(6);
        exp_a("idle_frames", 1'b0, 4'd3, 16'h0000, 16'h0000);
        sb_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-state controller sitting directly downstream of the sprite renderers. Consumes the cactus and dinosaur pixel streams and the frame strobe `fresh`, detects sprite collision, and runs the IDLE/RUN/OVER state machine. Drives `game_status` and `speed` back to the renderers, and `score`/`hi_score` to the score display.

## Interface
- SCORE_DIV, 6: frames per score point.
- SPEED_STEP, 600: RUN frames between speed increments.
- SPEED_INIT, 3: speed after reset and at every game start.
- SPEED_MAX, 15: speed saturation value.
- clkdiv  in  1  clock (pixel-domain clock); all logic on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- start  in  1  raw push-button, asynchronous to clkdiv.
- fresh  in  1  frame strobe; a falling edge marks end of frame.
- row_addr  in  9  current scan row.
- col_addr  in  10  current scan column.
- cactus_px  in  1  cactus renderer pixel, registered, aligned with dino_px.
- dino_px  in  1  dinosaur renderer pixel, same alignment.
- game_status  out  1  1 in RUN only.
- restart  out  1  one-cycle pulse on every entry to RUN.
- speed  out  4  current scroll speed.
- score  out  16  4-digit BCD score.
- hi_score  out  16  4-digit BCD best score.

## Operation
- start goes through a 2-flop synchronizer, then a rising-edge detect to give start_rise (one cycle).
- fresh is registered into fresh_q. frame_tick = fresh_q & ~fresh, one cycle wide.
- coincide = cactus_px & dino_px & (row_addr < 480) & (col_addr < 640).
- hit flag:
  - Set on coincide while in RUN.
  - Cleared on frame_tick and on entry to RUN.
  - The value evaluated at frame_tick is hit | coincide, so the tick cycle itself counts.
- States:
  - IDLE: start_rise → RUN.
  - RUN: frame_tick with collision → OVER.
  - OVER: start_rise → RUN.
  - No other transitions. RUN ignores start_rise.
- Entry to RUN:
  - score := 0, speed := SPEED_INIT.
  - Frame counters cleared, hit cleared.
  - restart = 1 for exactly that cycle.
- On each frame_tick in RUN without collision:
  - div_cnt increments. When it reaches SCORE_DIV-1 it wraps to 0 and score increments in BCD; score saturates at 9999.
  - step_cnt increments. When it reaches SPEED_STEP-1 it wraps to 0 and speed increments, saturating at SPEED_MAX.
- On the RUN→OVER tick:
  - No score or speed update.
  - If score > hi_score (BCD compare), hi_score := score.
  - score holds its value in OVER and IDLE.
- Simultaneous events:
  - start_rise together with frame_tick in IDLE/OVER: the transition to RUN wins and the tick is discarded.
  - Collision together with a score-increment tick: OVER wins.

## Timing
- Reset values:
  - game_status 0, restart 0, speed SPEED_INIT, score 0, hi_score 0.
  - State IDLE, all counters 0, synchronizer and fresh_q 0.
- All outputs are registered.
- start edge to game_status=1: 3 cycles (2 sync + 1 edge/state register).
- fresh falling edge to frame_tick: 1 cycle. Updates from the tick are visible on outputs 1 cycle after frame_tick.
- RESET asserted mid-game returns to IDLE immediately. No restart pulse is issued and hi_score is lost.
- Widths:
  - div_cnt is $clog2(SCORE_DIV) bits; step_cnt is 10 bits.
  - BCD compare is done digit-wise from most significant down.

## Structure
- Shared package dino_pkg holds:
  - state enum {IDLE, RUN, OVER}.
  - H_ACTIVE=640, V_ACTIVE=480.
  - SPEED_W=4, SCORE_W=16.
- One sub-module, bcd_counter4: 4-digit BCD counter.
  - Inputs: clear, inc. Output: value.
  - Saturates at 9999.
  - Instantiated once for score; hi_score is a plain register.

## Test plan
- Reset, then pulse start for 10 cycles → game_status=1 three cycles after start rises; restart high exactly one cycle; speed=3; score=0.
- 12 clean frames in RUN (SCORE_DIV=6) → score=0x0002; no collision → game_status stays 1.
- cactus_px=dino_px=1 for one cycle at row 350, col 100 during RUN → game_status=0 one cycle after the next frame_tick; hi_score=score; score unchanged.
- Same coincidence at col 700 (off-screen) → no transition.
- Force score to 9999, run 6 more frames → score stays 0x9999. Run 600×13 clean frames → speed saturates at 15.
- start rise in the same cycle as frame_tick in OVER → RUN, score=0. RESET mid-RUN → all outputs at reset values within 1 cycle, asynchronously.
